// File: rtl/mode_ctrl_pkg.sv
// Shared types and defaults for the button-driven mode controller.
package mode_ctrl_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        LOAD   = 2'b10
    } state_t;

    // 10 ms of stable level at 100 MHz
    localparam int DB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-level debouncer and rising-edge press pulse
// for one raw push-button.
module btn_debounce
    import mode_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic stable,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync;
    logic             stable_q;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] arm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync     <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            press    <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn_raw;
            sync     <= sync1;
            stable_q <= stable;
            press    <= armed & stable & ~stable_q;
            if (sync != stable) begin
                if (cnt == CNT_TC) begin
                    stable <= sync;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // A button already held when reset releases must not count as a press:
    // presses are only armed once a full debounce period of released level
    // has been seen through both synchroniser stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            arm_cnt <= '0;
        end else if (!armed) begin
            if (!sync1 && !sync) begin
                if (arm_cnt == CNT_TC) begin
                    armed <= 1'b1;
                end else begin
                    arm_cnt <= arm_cnt + CNT_W'(1);
                end
            end else begin
                arm_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mode_ctrl.sv
// Button front end for the switch/auto-count selector: debounces two buttons
// and turns presses into an auto-mode level and a one-cycle load strobe.
//
//   state  | meaning
//   MANUAL | selector follows switches, auto=0
//   AUTO   | selector auto-counts, auto=1
//   LOAD   | one-cycle preset strobe while in auto mode
module mode_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_auto,
    input  logic btn_load,
    output logic auto,
    output logic load,
    output logic mode_led
);

    logic   press_auto;
    logic   press_load;
    logic   stable_auto;
    logic   stable_load;
    logic   unused_stable;
    state_t state;
    state_t next_state;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_auto (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_auto),
        .stable  (stable_auto),
        .press   (press_auto)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_load),
        .stable  (stable_load),
        .press   (press_load)
    );

    assign unused_stable = stable_auto ^ stable_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MANUAL;
            auto     <= 1'b0;
            load     <= 1'b0;
            mode_led <= 1'b0;
        end else begin
            state    <= next_state;
            auto     <= (next_state != MANUAL);
            load     <= (next_state == LOAD);
            mode_led <= (next_state != MANUAL);
        end
    end

    // The toggle always beats a coincident load press.
    always_comb begin
        next_state = state;
        case (state)
            MANUAL: if (press_auto) next_state = AUTO;
            AUTO: begin
                if (press_auto)      next_state = MANUAL;
                else if (press_load) next_state = LOAD;
            end
            LOAD:    next_state = press_auto ? MANUAL : AUTO;
            default: next_state = MANUAL;
        endcase
    end

endmodule

// File: tb/tb_mode_ctrl.sv
// Scoreboard bench for mode_ctrl with a short debounce period.
module tb_mode_ctrl;
    import mode_ctrl_pkg::*;

    localparam int DBC = 4;
    localparam int LAT = DBC + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic btn_auto = 1'b0;
    logic btn_load = 1'b0;
    logic auto;
    logic load;
    logic mode_led;

    mode_ctrl #(.DB_CYCLES(DBC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_auto (btn_auto),
        .btn_load (btn_load),
        .auto     (auto),
        .load     (load),
        .mode_led (mode_led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   c;
        logic a;
        logic l;
    } exp_t;

    typedef enum int {EV_NONE, EV_ON, EV_OFF, EV_LOAD} ev_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;
    int   snap_n = 0;
    logic snap_a = 1'b0;
    logic snap_l = 1'b0;

    task automatic expect_ev(input int c, input logic a, input logic l);
        exp_t e;
        e.c = c;
        e.a = a;
        e.l = l;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit pa, input bit pl, input int hold, input ev_t ev);
        int e0;
        @(posedge clk);
        #1;
        e0 = cyc;
        if (pa) btn_auto = 1'b1;
        if (pl) btn_load = 1'b1;
        case (ev)
            EV_ON:   expect_ev(e0 + LAT, 1'b1, 1'b0);
            EV_OFF:  expect_ev(e0 + LAT, 1'b0, 1'b0);
            EV_LOAD: begin
                expect_ev(e0 + LAT, 1'b1, 1'b1);
                expect_ev(e0 + LAT + 1, 1'b1, 1'b0);
            end
            default: ;
        endcase
        repeat (hold) @(posedge clk);
        #1;
        if (pa) btn_auto = 1'b0;
        if (pl) btn_load = 1'b0;
        idle(14);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", nm, act, req, cyc);
        end
    endtask

    initial begin : stimulus
        int e0;
        btn_auto = 1'b1;
        btn_load = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(30);
        btn_auto = 1'b0;
        btn_load = 1'b0;
        idle(20);

        press(1'b1, 1'b0, 10, EV_ON);
        press(1'b1, 1'b0, 10, EV_OFF);

        for (int i = 0; i < 2; i++) begin
            btn_auto = 1'b1; idle(2);
            btn_auto = 1'b0; idle(2);
        end
        idle(20);
        for (int i = 0; i < 3; i++) begin
            btn_auto = 1'b1; idle(3);
            btn_auto = 1'b0; idle(6);
        end
        idle(10);

        press(1'b1, 1'b0, 10, EV_ON);
        press(1'b0, 1'b1, 10, EV_LOAD);
        press(1'b0, 1'b1, 50, EV_LOAD);

        press(1'b1, 1'b0, 10, EV_OFF);
        press(1'b0, 1'b1, 10, EV_NONE);

        press(1'b1, 1'b0, 10, EV_ON);
        press(1'b1, 1'b1, 10, EV_OFF);

        press(1'b1, 1'b0, 10, EV_ON);
        @(posedge clk);
        #1;
        e0 = cyc;
        btn_load = 1'b1;
        expect_ev(e0 + LAT, 1'b0, 1'b0);
        while (cyc < e0 + LAT) begin
            @(posedge clk);
            #1;
        end
        #1 rst_n = 1'b0;
        #1;
        snap_a = auto;
        snap_l = load;
        snap_n++;
        rst_n = 1'b1;
        idle(3);
        btn_load = 1'b0;
        idle(20);

        press(1'b1, 1'b0, 10, EV_ON);
        idle(5);
        done = 1'b1;
    end

    initial begin : monitor
        logic pa, pl, pled;
        int   seen;
        exp_t e;
        seen = 0;
        wait (rst_n == 1'b0);
        @(negedge clk);
        chk("reset_auto", int'(auto), 0);
        chk("reset_load", int'(load), 0);
        chk("reset_led", int'(mode_led), 0);
        wait (rst_n == 1'b1);
        pa = auto;
        pl = load;
        pled = mode_led;
        while (!done) begin
            @(negedge clk);
            if (snap_n != seen) begin
                seen = snap_n;
                chk("async_reset_auto", int'(snap_a), 0);
                chk("async_reset_load", int'(snap_l), 0);
            end
            if ({auto, load, mode_led} != {pa, pl, pled}) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output cyc=%0d auto=%b load=%b led=%b required=no change",
                             cyc, auto, load, mode_led);
                end else begin
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.c);
                    chk("event_auto", int'(auto), int'(e.a));
                    chk("event_load", int'(load), int'(e.l));
                    chk("event_led", int'(mode_led), int'(e.a));
                end
                pa = auto;
                pl = load;
                pled = mode_led;
            end else if (q.size() > 0 && cyc > q[0].c) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_event cyc=%0d actual auto=%b load=%b required auto=%b load=%b at cyc=%0d",
                         cyc, auto, load, e.a, e.l, e.c);
            end
        end
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
